// File: rtl/otp_pkg.sv
// otp_pkg: shared constants, FSM encoding and the pad LFSR step used by both ends
// of the one-time-pad link.
package otp_pkg;

   localparam int                 PAD_W     = 8;
   localparam int                 OTP_DEPTH = 8;
   localparam int                 OTP_IW    = $clog2(OTP_DEPTH);
   localparam logic [PAD_W-1:0]   OTP_SEED  = 8'h01;
   localparam logic [PAD_W-1:0]   OTP_TAPS  = 8'hB8;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } otp_state_e;

   // Shift left, feeding back the parity of the tapped bits.
   function automatic logic [PAD_W-1:0] lfsr_next(input logic [PAD_W-1:0] s,
                                                  input logic [PAD_W-1:0] taps);
      return {s[PAD_W-2:0], ^(s & taps)};
   endfunction

endpackage

// File: rtl/otp_lfsr_pad.sv
// otp_lfsr_pad: pad generator LFSR; pad is the current state, step advances it and
// reload (higher priority) returns it to SEED.
module otp_lfsr_pad
   import otp_pkg::*;
#(
   parameter logic [PAD_W-1:0] SEED = OTP_SEED,
   parameter logic [PAD_W-1:0] TAPS = OTP_TAPS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             reload,
   output logic [PAD_W-1:0] pad
);

   logic [PAD_W-1:0] lfsr_q;
   logic [PAD_W-1:0] lfsr_d;

   // Next LFSR state: reload wins over step.
   always_comb begin
      lfsr_d = lfsr_q;
      if (reload) begin
         lfsr_d = SEED;
      end else if (step) begin
         lfsr_d = lfsr_next(lfsr_q, TAPS);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // LFSR state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign pad = lfsr_q;

endmodule

// File: rtl/otp_decryptor_rx.sv
// otp_decryptor_rx: rebuilds the transmitter's pad stream into a ring and decrypts
// tagged ciphertext. Define OTP_SKIP_RESYNC_EN to recover from a forward index jump.
module otp_decryptor_rx
   import otp_pkg::*;
#(
   parameter int               DEPTH = OTP_DEPTH,
   parameter logic [PAD_W-1:0] SEED  = OTP_SEED,
   parameter logic [PAD_W-1:0] TAPS  = OTP_TAPS,
   localparam int              IW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             resync,
   input  logic             ct_valid,
   output logic             ct_ready,
   input  logic [PAD_W-1:0] ct_data,
   input  logic [IW-1:0]    ct_index,
   output logic             pt_valid,
   input  logic             pt_ready,
   output logic [PAD_W-1:0] pt_data,
   output logic [IW-1:0]    pt_index,
   output logic             sync_err,
   output logic [IW:0]      fill_level
);

   localparam logic [IW:0]   FULL_CNT = (IW+1)'(DEPTH);
   localparam logic [IW:0]   ZERO_CNT = {(IW+1){1'b0}};
   localparam logic [IW:0]   ONE_CNT  = {{IW{1'b0}}, 1'b1};
   localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};
   localparam logic [IW-1:0] ONE_IDX  = {{(IW-1){1'b0}}, 1'b1};

   logic [PAD_W-1:0] pad_q [DEPTH];
   logic [PAD_W-1:0] pad_d [DEPTH];
   logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [IW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [IW:0]      count_q, count_d;
   otp_state_e       state_q, state_d;
   logic             pt_valid_q, pt_valid_d;
   logic [PAD_W-1:0] pt_data_q, pt_data_d;
   logic [IW-1:0]    pt_index_q, pt_index_d;
   logic             sync_err_q, sync_err_d;

   logic [PAD_W-1:0] lfsr_s;
   logic             gen_s;
   logic             ct_ready_s;
   logic             accept_s;
   logic             hit_s;
   logic             consume_s;
   logic             reject_s;
   logic [IW-1:0]    pad_sel_s;
   logic [IW:0]      used_s;
`ifdef OTP_SKIP_RESYNC_EN
   logic [IW-1:0]    dist_s;
`endif

   otp_lfsr_pad #(
      .SEED (SEED),
      .TAPS (TAPS)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (gen_s),
      .reload (resync),
      .pad    (lfsr_s)
   );

   // Handshake decode and index check for the byte on the link.
   always_comb begin
      ct_ready_s = en && (state_q == ST_RUN) && (count_q != ZERO_CNT) &&
                   (!pt_valid_q || pt_ready);
      gen_s      = en && (count_q < FULL_CNT) && (state_q != ST_ERR);
      accept_s   = ct_valid && ct_ready_s;
`ifdef OTP_SKIP_RESYNC_EN
      // A forward jump is tolerated while the tagged pad is still buffered.
      dist_s     = ct_index - rd_ptr_q;
      hit_s      = ({1'b0, dist_s} < count_q);
      pad_sel_s  = ct_index;
      used_s     = {1'b0, dist_s} + ONE_CNT;
`else
      hit_s      = (ct_index == rd_ptr_q);
      pad_sel_s  = rd_ptr_q;
      used_s     = ONE_CNT;
`endif
      consume_s  = accept_s && hit_s;
      reject_s   = accept_s && !hit_s;
   end

   // Next-state logic for the ring, pointers, output stage and FSM.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pad_d[i] = (gen_s && !resync && (wr_ptr_q == IW'(i))) ? lfsr_s : pad_q[i];
      end
      if (resync) begin
         wr_ptr_d   = ZERO_IDX;
         rd_ptr_d   = ZERO_IDX;
         count_d    = ZERO_CNT;
         pt_valid_d = 1'b0;
         pt_data_d  = pt_data_q;
         pt_index_d = pt_index_q;
         sync_err_d = 1'b0;
         state_d    = ST_FILL;
      end else begin
         wr_ptr_d   = gen_s ? (wr_ptr_q + ONE_IDX) : wr_ptr_q;
         rd_ptr_d   = consume_s ? (pad_sel_s + ONE_IDX) : rd_ptr_q;
         count_d    = count_q + (gen_s ? ONE_CNT : ZERO_CNT) - (consume_s ? used_s : ZERO_CNT);
         pt_valid_d = consume_s || (pt_valid_q && !(en && pt_ready));
         pt_data_d  = consume_s ? (ct_data ^ pad_q[pad_sel_s]) : pt_data_q;
         pt_index_d = consume_s ? pad_sel_s : pt_index_q;
         sync_err_d = sync_err_q || reject_s;
         case (state_q)
            ST_FILL: state_d = (count_d == FULL_CNT) ? ST_RUN : ST_FILL;
            ST_RUN:  state_d = reject_s ? ST_ERR : ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_FILL;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pad_q[i] <= {PAD_W{1'b0}};
         end
         wr_ptr_q   <= ZERO_IDX;
         rd_ptr_q   <= ZERO_IDX;
         count_q    <= ZERO_CNT;
         state_q    <= ST_FILL;
         pt_valid_q <= 1'b0;
         pt_data_q  <= {PAD_W{1'b0}};
         pt_index_q <= ZERO_IDX;
         sync_err_q <= 1'b0;
      end else begin
         pad_q      <= pad_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         pt_valid_q <= pt_valid_d;
         pt_data_q  <= pt_data_d;
         pt_index_q <= pt_index_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign ct_ready   = ct_ready_s;
   assign pt_valid   = pt_valid_q;
   assign pt_data    = pt_data_q;
   assign pt_index   = pt_index_q;
   assign sync_err   = sync_err_q;
   assign fill_level = count_q;

endmodule

// File: tb/tb_otp_decryptor_rx.sv
// tb_otp_decryptor_rx: directed vectors for otp_decryptor_rx with hand-computed pads
// (SEED 8'h01, TAPS 8'hB8).
module tb_otp_decryptor_rx;

   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n, en, resync, ct_valid, ct_ready, pt_valid, pt_ready, sync_err;
   logic [7:0]    ct_data, pt_data;
   logic [IW-1:0] ct_index, pt_index;
   logic [IW:0]   fill_level;

   int checks = 0;
   int errors = 0;

   // Pad sequence p0..p24 worked out by hand from next = {s[6:0], ^(s & 8'hB8)}.
   logic [7:0] pad_tbl [25] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                                8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25,
                                8'h4B, 8'h97, 8'h2E, 8'h5C, 8'hB8, 8'h70, 8'hE0, 8'hC0,
                                8'h81};

   logic [7:0] ct_b, exp_b;

   always #5 clk = ~clk;

   otp_decryptor_rx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .resync     (resync),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .ct_data    (ct_data),
      .ct_index   (ct_index),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .pt_data    (pt_data),
      .pt_index   (pt_index),
      .sync_err   (sync_err),
      .fill_level (fill_level)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [IW-1:0] idx);
      ct_valid = 1'b1;
      ct_data  = d;
      ct_index = idx;
   endtask

   initial begin
      rst_n    = 1'b1;
      en       = 1'b0;
      resync   = 1'b0;
      ct_valid = 1'b0;
      ct_data  = 8'h00;
      ct_index = 3'd0;
      pt_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_pt_valid", 32'(pt_valid), 32'd0);
      check("rst_pt_data", 32'(pt_data), 32'h00);
      check("rst_pt_index", 32'(pt_index), 32'd0);
      check("rst_sync_err", 32'(sync_err), 32'd0);
      check("rst_fill", 32'(fill_level), 32'd0);
      check("rst_ct_ready", 32'(ct_ready), 32'd0);

      // Fill: one pad per cycle, no accept until the ring is full.
      tick();
      rst_n = 1'b1;
      en    = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("fill_level", 32'(fill_level), 32'(i));
         if (i < 8) check("fill_ct_ready", 32'(ct_ready), 32'd0);
      end
      check("run_ct_ready", 32'(ct_ready), 32'd1);
      tick();
      check("full_hold", 32'(fill_level), 32'd8);

      // Back-to-back decrypt with pads p0..p2.
      pt_ready = 1'b1;
      send(8'h41, 3'd0);
      tick();
      check("b2b0_valid", 32'(pt_valid), 32'd1);
      check("b2b0_data", 32'(pt_data), 32'h40);
      check("b2b0_index", 32'(pt_index), 32'd0);
      check("b2b0_fill", 32'(fill_level), 32'd7);
      send(8'h43, 3'd1);
      tick();
      check("b2b1_data", 32'(pt_data), 32'h41);
      check("b2b1_index", 32'(pt_index), 32'd1);
      check("b2b1_fill", 32'(fill_level), 32'd7);
      send(8'h00, 3'd2);
      tick();
      check("b2b2_data", 32'(pt_data), 32'h04);
      check("b2b2_index", 32'(pt_index), 32'd2);
      ct_valid = 1'b0;
      tick();
      check("b2b_drain", 32'(pt_valid), 32'd0);
      check("b2b_refill", 32'(fill_level), 32'd8);

      // Backpressure: pt held while pt_ready is low.
      pt_ready = 1'b0;
      send(8'hAA, 3'd3);
      tick();
      check("bp_data", 32'(pt_data), 32'(8'hAA ^ 8'h08));
      check("bp_ct_ready", 32'(ct_ready), 32'd0);
      send(8'h5A, 3'd4);
      for (int j = 0; j < 2; j++) begin
         tick();
         check("bp_hold_valid", 32'(pt_valid), 32'd1);
         check("bp_hold_data", 32'(pt_data), 32'h A2);
         check("bp_hold_index", 32'(pt_index), 32'd3);
      end
      check("bp_fill", 32'(fill_level), 32'd8);
      pt_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(ct_ready), 32'd1);
      tick();
      check("bp_next_data", 32'(pt_data), 32'(8'h5A ^ 8'h11));
      check("bp_next_index", 32'(pt_index), 32'd4);
      ct_valid = 1'b0;
      tick();
      check("bp_drain", 32'(pt_valid), 32'd0);

      // Streaming run of 20 bytes using pads p5..p24, with an enable freeze midway.
      for (int k = 0; k < 20; k++) begin
         ct_b = 8'((k * 29) + 7);
         send(ct_b, 3'((k + 5) % 8));
         tick();
         exp_b = ct_b ^ pad_tbl[k + 5];
         check("run_data", 32'(pt_data), 32'(exp_b));
         check("run_index", 32'(pt_index), 32'((k + 5) % 8));
         check("run_fill", 32'(fill_level), 32'd7);
         if (k == 9) begin
            en = 1'b0;
            #1;
            check("frz_ct_ready", 32'(ct_ready), 32'd0);
            for (int j = 0; j < 5; j++) tick();
            check("frz_valid", 32'(pt_valid), 32'd1);
            check("frz_data", 32'(pt_data), 32'(exp_b));
            check("frz_index", 32'(pt_index), 32'd6);
            check("frz_fill", 32'(fill_level), 32'd7);
            en = 1'b1;
         end
      end

      // Asynchronous reset in the middle of a transfer.
      send(8'hEE, 3'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pt_valid", 32'(pt_valid), 32'd0);
      check("arst_pt_data", 32'(pt_data), 32'h00);
      check("arst_pt_index", 32'(pt_index), 32'd0);
      check("arst_fill", 32'(fill_level), 32'd0);
      check("arst_ct_ready", 32'(ct_ready), 32'd0);
      ct_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("refill", 32'(fill_level), 32'd8);

`ifdef OTP_SKIP_RESYNC_EN
      send(8'h00, 3'd3);
      tick();
      ct_valid = 1'b0;
      check("skip_data", 32'(pt_data), 32'h08);
      check("skip_index", 32'(pt_index), 32'd3);
      check("skip_fill", 32'(fill_level), 32'd4);
      check("skip_sync_err", 32'(sync_err), 32'd0);
      tick();
      check("skip_refill", 32'(fill_level), 32'd5);
`else
      send(8'h55, 3'd3);
      tick();
      ct_valid = 1'b0;
      check("err_sync_err", 32'(sync_err), 32'd1);
      check("err_ct_ready", 32'(ct_ready), 32'd0);
      check("err_no_pt", 32'(pt_valid), 32'd0);
      tick();
      check("err_sticky", 32'(sync_err), 32'd1);
      check("err_fill", 32'(fill_level), 32'd8);
`endif

      // Resync restarts the pad sequence at the seed.
      resync = 1'b1;
      tick();
      resync = 1'b0;
      check("rsy_sync_err", 32'(sync_err), 32'd0);
      check("rsy_fill", 32'(fill_level), 32'd0);
      check("rsy_ct_ready", 32'(ct_ready), 32'd0);
      for (int i = 0; i < 8; i++) tick();
      check("rsy_refill", 32'(fill_level), 32'd8);
      send(8'h41, 3'd0);
      tick();
      check("rsy_data0", 32'(pt_data), 32'h40);
      check("rsy_index0", 32'(pt_index), 32'd0);
      send(8'h12, 3'd1);
      tick();
      check("rsy_data1", 32'(pt_data), 32'h10);
      check("rsy_index1", 32'(pt_index), 32'd1);
      ct_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
